// File: rtl/cache_types.sv
// Shared types and constants for the cache-line to memory-burst arbiter.
package cache_types;
  localparam int LINE_W   = 256;
  localparam int MEM_W    = 64;
  localparam int BEATS    = LINE_W / MEM_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int OFF_BITS = 5;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} arb_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:OFF_BITS], {OFF_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/line_beat_buffer.sv
// One cache line plus beat counter: assembles read beats, serves write beats.
module line_beat_buffer
  import cache_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              beat_en,
  input  logic              cap_en,
  input  logic [MEM_W-1:0]  beat_in,
  output logic [LINE_W-1:0] line_next,
  output logic [MEM_W-1:0]  beat_out,
  output logic              last_beat
);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  // line_next is the line with the incoming beat dropped into the current slot
  genvar gi;
  for (gi = 0; gi < BEATS; gi++) begin : g_beat
    assign line_next[gi*MEM_W +: MEM_W] =
      (cnt_q == CNT_W'(gi)) ? beat_in : line_q[gi*MEM_W +: MEM_W];
  end

  assign beat_out  = line_q[int'(cnt_q)*MEM_W +: MEM_W];
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (clr) begin
      line_d = '0;
      cnt_d  = '0;
    end else if (load) begin
      line_d = load_line;
      cnt_d  = '0;
    end else if (beat_en) begin
      cnt_d = cnt_q + 1'b1;
      if (cap_en) line_d = line_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/line_burst_arbiter.sv
// Shares one 64-bit burst memory port between icache and dcache line ports.
// Define LINE_ARB_RR_EN for round-robin on contention; otherwise dcache has fixed priority.
module line_burst_arbiter
  import cache_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read_c_i,
  input  logic [31:0]       pmem_address_c_i,
  output logic [LINE_W-1:0] pmem_rdata_c_i,
  output logic              pmem_resp_c_i,
  input  logic              pmem_read_c_d,
  input  logic              pmem_write_c_d,
  input  logic [31:0]       pmem_address_c_d,
  input  logic [LINE_W-1:0] pmem_wdata_c_d,
  output logic [LINE_W-1:0] pmem_rdata_c_d,
  output logic              pmem_resp_c_d,
  output logic              pmem_read_m,
  output logic              pmem_write_m,
  output logic [31:0]       pmem_address_m,
  output logic [MEM_W-1:0]  pmem_wdata_m,
  input  logic [MEM_W-1:0]  pmem_rdata_m,
  input  logic              pmem_resp_m
);
  arb_state_t        state_q, state_d;
  grant_t            grant_q, grant_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] rdata_i_q, rdata_i_d, rdata_d_q, rdata_d_d;
  logic              buf_clr, buf_load, buf_beat, buf_cap, last_beat;
  logic [LINE_W-1:0] buf_line_next;
  logic              req_i, req_d, pick_d;

  assign req_i = pmem_read_c_i;
  assign req_d = pmem_read_c_d | pmem_write_c_d;

`ifdef LINE_ARB_RR_EN
  logic last_d_q, last_d_d;

  assign pick_d = req_d && (!req_i || !last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && grant_d != GNT_NONE) last_d_d = (grant_d == GNT_D);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_d_q <= 1'b0;
    else      last_d_q <= last_d_d;
  end
`else
  assign pick_d = req_d;
`endif

  line_beat_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .load      (buf_load),
    .load_line (pmem_wdata_c_d),
    .beat_en   (buf_beat),
    .cap_en    (buf_cap),
    .beat_in   (pmem_rdata_m),
    .line_next (buf_line_next),
    .beat_out  (pmem_wdata_m),
    .last_beat (last_beat)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    rdata_i_d = rdata_i_q;
    rdata_d_d = rdata_d_q;
    buf_clr   = 1'b0;
    buf_load  = 1'b0;
    buf_beat  = 1'b0;
    buf_cap   = 1'b0;
    case (state_q)
      IDLE: begin
        // a simultaneous read+write from dcache is a writeback first
        if (pick_d) begin
          grant_d = GNT_D;
          addr_d  = line_base(pmem_address_c_d);
          if (pmem_write_c_d) begin
            state_d  = WR_BURST;
            buf_load = 1'b1;
          end else begin
            state_d = RD_BURST;
            buf_clr = 1'b1;
          end
        end else if (req_i) begin
          grant_d = GNT_I;
          addr_d  = line_base(pmem_address_c_i);
          state_d = RD_BURST;
          buf_clr = 1'b1;
        end
      end
      RD_BURST: begin
        if (pmem_resp_m) begin
          buf_beat = 1'b1;
          buf_cap  = 1'b1;
          if (last_beat) begin
            state_d = DONE;
            if (grant_q == GNT_I) rdata_i_d = buf_line_next;
            else                  rdata_d_d = buf_line_next;
          end
        end
      end
      WR_BURST: begin
        if (pmem_resp_m) begin
          buf_beat = 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= GNT_NONE;
      addr_q    <= '0;
      rdata_i_q <= '0;
      rdata_d_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      rdata_i_q <= rdata_i_d;
      rdata_d_q <= rdata_d_d;
    end
  end

  assign pmem_read_m    = (state_q == RD_BURST);
  assign pmem_write_m   = (state_q == WR_BURST);
  assign pmem_address_m = addr_q;
  assign pmem_resp_c_i  = (state_q == DONE) && (grant_q == GNT_I);
  assign pmem_resp_c_d  = (state_q == DONE) && (grant_q == GNT_D);
  assign pmem_rdata_c_i = rdata_i_q;
  assign pmem_rdata_c_d = rdata_d_q;
endmodule

// File: tb/tb_line_burst_arbiter.sv
// Scoreboard bench for line_burst_arbiter: random line traffic against a line-level memory model.
module tb_line_burst_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pmem_read_c_i = 1'b0;
  logic [31:0]  pmem_address_c_i = '0;
  logic [255:0] pmem_rdata_c_i;
  logic         pmem_resp_c_i;
  logic         pmem_read_c_d = 1'b0;
  logic         pmem_write_c_d = 1'b0;
  logic [31:0]  pmem_address_c_d = '0;
  logic [255:0] pmem_wdata_c_d = '0;
  logic [255:0] pmem_rdata_c_d;
  logic         pmem_resp_c_d;
  logic         pmem_read_m;
  logic         pmem_write_m;
  logic [31:0]  pmem_address_m;
  logic [63:0]  pmem_wdata_m;
  logic [63:0]  pmem_rdata_m = '0;
  logic         pmem_resp_m = 1'b0;

  line_burst_arbiter dut (
    .clk(clk), .rst(rst),
    .pmem_read_c_i(pmem_read_c_i), .pmem_address_c_i(pmem_address_c_i),
    .pmem_rdata_c_i(pmem_rdata_c_i), .pmem_resp_c_i(pmem_resp_c_i),
    .pmem_read_c_d(pmem_read_c_d), .pmem_write_c_d(pmem_write_c_d),
    .pmem_address_c_d(pmem_address_c_d), .pmem_wdata_c_d(pmem_wdata_c_d),
    .pmem_rdata_c_d(pmem_rdata_c_d), .pmem_resp_c_d(pmem_resp_c_d),
    .pmem_read_m(pmem_read_m), .pmem_write_m(pmem_write_m),
    .pmem_address_m(pmem_address_m), .pmem_wdata_m(pmem_wdata_m),
    .pmem_rdata_m(pmem_rdata_m), .pmem_resp_m(pmem_resp_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           who_d;
    bit           is_wr;
    logic [31:0]  base;
    logic [255:0] line;
    int           exp_lat;
    int           t_issue;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [63:0]  phys[logic [31:0]];
  logic [255:0] ref_mem[logic [31:0]];
  logic [255:0] hold_i = '0;
  logic [255:0] hold_d = '0;
  bit           last_d_model = 1'b0;
  int           stall_pct = 0;
  int           stall_at = -1;
  int           stall_cnt = 0;
  int           stalls_done = 0;
  int           nbeats = 0;
  bit           in_burst = 1'b0;
  logic [31:0]  cur_addr = '0;
  bit           cur_wr = 1'b0;
  logic [31:0]  burst_addr = '0;
  int           burst_beats = 0;
  bit           burst_wr = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [63:0] init_word(input logic [31:0] w);
    return {w, ~w};
  endfunction

  function automatic logic [63:0] phys_rd(input logic [31:0] w);
    if (phys.exists(w)) return phys[w];
    return init_word(w);
  endfunction

  function automatic logic [255:0] ref_rd(input logic [31:0] base);
    logic [255:0] l;
    if (ref_mem.exists(base)) return ref_mem[base];
    for (int b = 0; b < 4; b++) l[64*b +: 64] = init_word((base >> 3) + 32'(b));
    return l;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Memory responder: serves beats from phys, random or scripted stalls
  initial begin
    bit           give;
    logic [255:0] wl;
    logic [31:0]  w;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b0) begin
        pmem_resp_m = 1'b0;
        in_burst = 1'b0;
        nbeats = 0;
      end else if (pmem_read_m || pmem_write_m) begin
        check("rd_wr_exclusive", pmem_read_m & pmem_write_m, 0);
        if (!in_burst) begin
          in_burst = 1'b1;
          cur_addr = pmem_address_m;
          cur_wr = pmem_write_m;
          nbeats = 0;
          stalls_done = 0;
        end else begin
          check("addr_const", pmem_address_m, cur_addr);
        end
        if (pmem_write_m && sb.size() > 0 && nbeats < 4) begin
          wl = sb[0].line;
          check("wdata_beat", pmem_wdata_m, wl[nbeats*64 +: 64]);
        end
        give = 1'b1;
        if (nbeats == stall_at && stalls_done < stall_cnt) begin
          give = 1'b0;
          stalls_done++;
        end else if (int'($urandom_range(0, 99)) < stall_pct) begin
          give = 1'b0;
        end
        w = (cur_addr >> 3) + 32'(nbeats);
        if (give) begin
          pmem_resp_m = 1'b1;
          if (pmem_read_m) pmem_rdata_m = phys_rd(w);
          else             phys[w] = pmem_wdata_m;
          nbeats++;
        end else begin
          pmem_resp_m = 1'b0;
          pmem_rdata_m = {$urandom(), $urandom()};
        end
      end else begin
        if (in_burst) begin
          burst_addr = cur_addr;
          burst_beats = nbeats;
          burst_wr = cur_wr;
          in_burst = 1'b0;
          nbeats = 0;
        end
        pmem_resp_m = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every cache response
  initial begin
    bit   prev_i = 1'b0;
    bit   prev_d = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (pmem_resp_c_i) check("resp_i_one_cycle", prev_i, 0);
      if (pmem_resp_c_d) check("resp_d_one_cycle", prev_d, 0);
      if (pmem_resp_c_i || pmem_resp_c_d) begin
        check("resp_exclusive", pmem_resp_c_i & pmem_resp_c_d, 0);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp: got resp_i=%0b resp_d=%0b want none", pmem_resp_c_i, pmem_resp_c_d);
        end else begin
          e = sb.pop_front();
          check("grant_who_d", pmem_resp_c_d, e.who_d);
          check("burst_addr", burst_addr, e.base);
          check("burst_beats", burst_beats, 4);
          check("burst_is_write", burst_wr, e.is_wr);
          if (!e.is_wr) begin
            if (e.who_d) hold_d = e.line;
            else         hold_i = e.line;
          end
          check("rdata_i", pmem_rdata_c_i, hold_i);
          check("rdata_d", pmem_rdata_c_d, hold_d);
          if (e.exp_lat >= 0) check("latency", cyc - e.t_issue, e.exp_lat);
          $display("txn %s %s base=%h t=%0d", e.who_d ? "D" : "I", e.is_wr ? "WR" : "RD", e.base, cyc);
        end
      end
      prev_i = pmem_resp_c_i;
      prev_d = pmem_resp_c_d;
    end
  end

  task automatic run_i(input logic [31:0] a, input bit drop);
    int n = 0;
    bit done = 1'b0;
    pmem_address_c_i = a;
    pmem_read_c_i = 1'b1;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (drop && in_burst && nbeats >= 2) pmem_read_c_i = 1'b0;
      if (pmem_resp_c_i) done = 1'b1;
    end
    pmem_read_c_i = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout_i: got no resp in 300 cycles want resp");
    end
  endtask

  task automatic run_d(input logic [31:0] a, input bit rd, input bit wr, input logic [255:0] wd);
    int n = 0;
    bit done = 1'b0;
    pmem_address_c_d = a;
    pmem_wdata_c_d = wd;
    pmem_read_c_d = rd;
    pmem_write_c_d = wr;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (pmem_resp_c_d) done = 1'b1;
    end
    pmem_read_c_d = 1'b0;
    pmem_write_c_d = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout_d: got no resp in 300 cycles want resp");
    end
  endtask

  task automatic push_i(input logic [31:0] a, input int lat);
    exp_t e;
    e.who_d = 1'b0;
    e.is_wr = 1'b0;
    e.base = a & ~32'h1F;
    e.line = ref_rd(e.base);
    e.exp_lat = lat;
    e.t_issue = cyc;
    sb.push_back(e);
    last_d_model = 1'b0;
  endtask

  task automatic push_d(input logic [31:0] a, input bit wr, input logic [255:0] wd, input int lat);
    exp_t e;
    e.who_d = 1'b1;
    e.is_wr = wr;
    e.base = a & ~32'h1F;
    e.line = wr ? wd : ref_rd(e.base);
    if (wr) ref_mem[e.base] = wd;
    e.exp_lat = lat;
    e.t_issue = cyc;
    sb.push_back(e);
    last_d_model = 1'b1;
  endtask

  // Service order follows the arbitration rule; a write wins over a read on dcache
  task automatic issue(input bit do_i, input bit do_d, input bit d_rd, input bit d_wr,
                       input logic [31:0] ai, input logic [31:0] ad, input logic [255:0] wd,
                       input bit drop, input int lat);
    bit d_first;
    @(posedge clk); #1;
`ifdef LINE_ARB_RR_EN
    d_first = do_d && (!do_i || !last_d_model);
`else
    d_first = do_d;
`endif
    if (d_first) begin
      push_d(ad, d_wr, wd, lat);
      if (do_i) push_i(ai, lat);
    end else begin
      if (do_i) push_i(ai, lat);
      if (do_d) push_d(ad, d_wr, wd, lat);
    end
    fork
      if (do_i) run_i(ai, drop);
      if (do_d) run_d(ad, d_rd, d_wr, wd);
    join
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom();
    return l;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          kind;
    logic [31:0] ai, ad;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_m", pmem_read_m, 0);
    check("rst_write_m", pmem_write_m, 0);
    check("rst_resp_i", pmem_resp_c_i, 0);
    check("rst_resp_d", pmem_resp_c_d, 0);
    check("rst_addr_m", pmem_address_m, 0);
    check("rst_wdata_m", pmem_wdata_m, 0);
    check("rst_rdata_i", pmem_rdata_c_i, 0);
    check("rst_rdata_d", pmem_rdata_c_d, 0);
    @(negedge clk) rst = 1'b1;

    // icache read with fixed beat pattern, no stalls
    for (int b = 0; b < 4; b++) phys[(32'h1060 >> 3) + 32'(b)] = {16{4'(b + 1)}};
    ref_mem[32'h1060] = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    issue(1, 0, 0, 0, 32'h0000_1064, '0, '0, 0, 5);

    // dcache writeback with two stall cycles before beat 2
    stall_at = 2;
    stall_cnt = 2;
    issue(0, 1, 0, 1, '0, 32'h8000_0020, {8{32'hDEAD_BEEF}}, 0, 7);
    stall_at = -1;
    issue(1, 0, 0, 0, 32'h8000_0020, '0, '0, 0, 5);

    // two contended read rounds
    issue(1, 1, 1, 0, 32'h0000_2000, 32'h0000_3000, '0, 0, -1);
    issue(1, 1, 1, 0, 32'h0000_2020, 32'h0000_3020, '0, 0, -1);

    // dcache read and write together: writeback only
    issue(0, 1, 1, 1, '0, 32'h0000_0100, rand_line(), 0, 5);

    // icache drops its request after beat 1
    issue(1, 0, 0, 0, 32'h0000_0100, '0, '0, 1, 5);

    // reset in the middle of a read burst
    @(posedge clk); #1;
    pmem_address_c_i = 32'h0000_5040;
    pmem_read_c_i = 1'b1;
    n = 0;
    while (!(in_burst && nbeats >= 2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_burst_reached", nbeats >= 2, 1);
    rst = 1'b0;
    #1;
    check("arst_read_m", pmem_read_m, 0);
    check("arst_write_m", pmem_write_m, 0);
    check("arst_resp_i", pmem_resp_c_i, 0);
    check("arst_resp_d", pmem_resp_c_d, 0);
    check("arst_addr_m", pmem_address_m, 0);
    check("arst_rdata_i", pmem_rdata_c_i, 0);
    check("arst_rdata_d", pmem_rdata_c_d, 0);
    pmem_read_c_i = 1'b0;
    hold_i = '0;
    hold_d = '0;
    last_d_model = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (6) @(negedge clk);
    issue(1, 0, 0, 0, 32'h0000_5040, '0, '0, 0, 5);

    // random traffic over four lines with random stalls
    stall_pct = 25;
    for (int r = 0; r < 60; r++) begin
      kind = int'($urandom_range(0, 5));
      ai = 32'h4000 + ($urandom_range(0, 3) << 5) + $urandom_range(0, 31);
      ad = 32'h4000 + ($urandom_range(0, 3) << 5) + $urandom_range(0, 31);
      case (kind)
        0: issue(1, 0, 0, 0, ai, ad, '0, 0, -1);
        1: issue(0, 1, 1, 0, ai, ad, '0, 0, -1);
        2: issue(0, 1, 0, 1, ai, ad, rand_line(), 0, -1);
        3: issue(0, 1, 1, 1, ai, ad, rand_line(), 0, -1);
        4: issue(1, 1, 1, 0, ai, ad, '0, 0, -1);
        default: issue(1, 1, 0, 1, ai, ad, rand_line(), 0, -1);
      endcase
    end

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_burst_arbiter.md
Name: line_burst_arbiter

Overview:
- Shares the single 64-bit burst physical-memory port between the instruction cache (read-only) and the data cache (read/write).
- Converts each 256-bit cache-line transfer into a 4-beat memory burst: assembles beats for reads, splits the line for writebacks.
- Sits between the two caches and the memory port in the top level, replacing direct wiring of cache line ports.

Parameters:
- LINE_W, 256, cache line width in bits.
- MEM_W, 64, memory beat width in bits; BEATS = LINE_W/MEM_W (4), derived, not overridable.
- OFF_BITS, 5, line-offset bits forced to zero on pmem_address_m.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset: asynchronous, active-low (rst=0 resets).
- pmem_read_c_i  in  1  icache line-read request.
- pmem_address_c_i  in  32  icache line address.
- pmem_rdata_c_i  out  LINE_W  line returned to icache.
- pmem_resp_c_i  out  1  icache completion pulse.
- pmem_read_c_d  in  1  dcache line-read request.
- pmem_write_c_d  in  1  dcache line-writeback request.
- pmem_address_c_d  in  32  dcache line address.
- pmem_wdata_c_d  in  LINE_W  dcache writeback line.
- pmem_rdata_c_d  out  LINE_W  line returned to dcache.
- pmem_resp_c_d  out  1  dcache completion pulse.
- pmem_read_m  out  1  memory burst read.
- pmem_write_m  out  1  memory burst write.
- pmem_address_m  out  32  burst base address, low OFF_BITS zero.
- pmem_wdata_m  out  MEM_W  current write beat.
- pmem_rdata_m  in  MEM_W  current read beat.
- pmem_resp_m  in  1  per-beat acknowledge from memory.

Behaviour:
- Reset (rst=0, async): state IDLE, beat counter 0, grant none, line buffer 0. All outputs 0 until first post-reset edge, including both rdata buses.
- Reset mid-burst: memory request drops immediately and no cache response is issued. Caches re-request after reset.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE, arbitration on registered state:
  - dcache wins over icache when both request.
  - If pmem_write_c_d and pmem_read_c_d are both high, the write wins.
  - Grant, address (low 5 bits cleared) and write line are latched into registers. Next state is RD_BURST or WR_BURST.
- RD_BURST / WR_BURST:
  - pmem_read_m or pmem_write_m is held high, with a constant pmem_address_m, for the whole burst.
  - Each cycle with pmem_resp_m=1 is one beat. Beat k occupies bits [64k+63:64k], beat 0 first.
  - Read: beat k is captured into the line buffer.
  - Write: pmem_wdata_m presents beat k of the latched line, combinationally from the counter. It advances on the same edge the resp is sampled.
  - After the beat-3 resp: counter wraps to 0, memory request deasserts next cycle, next state DONE.
  - The counter does not advance on cycles with pmem_resp_m=0.
- DONE:
  - Exactly one-cycle pulse on the granted requester's pmem_resp_c_x. Next state IDLE.
  - The non-granted resp stays 0.
- Latency: an uncontended line costs 1 (grant) + beat cycles + 1 (DONE). Minimum is 6 cycles from request to resp.
- rdata to a requester is driven from the line buffer only for the requester that was granted. It stays stable from its DONE cycle until that requester's next read completes. The other requester's rdata bus holds its previous value.
- Requests are level-held by caches until resp. A request deasserted mid-burst is ignored and the burst completes.
- A requester asserting on the IDLE cycle following its own DONE is treated as a new request.
- pmem_read_m and pmem_write_m are never high simultaneously.

Optional Feature:
- LINE_ARB_RR_EN defined: round-robin fairness. On simultaneous icache/dcache requests in IDLE, grant goes to the requester not served last. The last-served flag resets to icache, so the first contended grant goes to dcache.
- Not defined: fixed dcache priority as above.

Decomposition:
- Shared package cache_types:
  - arb_state_t enum (IDLE, RD_BURST, WR_BURST, DONE).
  - grant_t enum (GNT_NONE, GNT_I, GNT_D).
  - constants LINE_W, MEM_W, BEATS, OFF_BITS.
- One sub-module, line_beat_buffer:
  - 256-bit register plus 2-bit beat counter.
  - Captures beats on read; muxes beats out on write.
  - Inputs: clear, capture enable, write-line load.

Test Plan:
- icache read 0x0000_1064, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp every cycle.
  - Expect pmem_address_m=0x0000_1060 and pmem_rdata_c_i={0x44..,0x33..,0x22..,0x11..}.
  - Expect a single pmem_resp_c_i pulse at cycle 6.
- dcache write 0x8000_0020, line 0xDEAD_BEEF repeated, memory inserts 2 stall cycles before beat 2.
  - Expect pmem_wdata_m to hold beat 2 across the stalls and 4 accepted beats total.
  - Expect pmem_resp_c_d pulse after the final beat + 1.
- icache and dcache read asserted same cycle.
  - Without LINE_ARB_RR_EN: dcache served first, icache next.
  - With LINE_ARB_RR_EN: two consecutive contended rounds alternate grants: dcache then icache.
- dcache read and write both high on 0x0000_0100 -> a write burst is issued; pmem_read_m stays 0 throughout.
- rst driven low during beat 2 of a read.
  - Expect pmem_read_m=0 asynchronously, no resp, and all outputs 0.
  - After release, a fresh request completes normally.
- icache drops pmem_read_c_i after beat 1 -> burst still completes 4 beats, and a resp pulse is still issued.
